// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// UART transmit stage fed by the ADC control FSM. Single-cycle write strobes
// push data words into a small FIFO; a frame FSM pops them one at a time and
// shifts each out on `tx` as a start bit, NUM_DATA data bits (LSB first) and a
// stop bit. Each bit lasts DIV = CLK_FREQ / BAUDRATE clock cycles. When the
// FIFO still holds data at the end of a stop bit, the next start bit follows
// on the very next cycle, so queued words go out as contiguous frames.
//
// Parameters
//   CLK_FREQ   clock frequency in Hz
//   BAUDRATE   line rate in bit/s; DIV = CLK_FREQ / BAUDRATE must be >= 2
//   NUM_DATA   data bits per frame
//   FIFO_AW    FIFO address width; depth is 2**FIFO_AW
//
// Ports
//   clk         in   system clock
//   nrst        in   asynchronous active-low reset
//   pll_locked  in   low clears FIFO, FSM, busy and overflow at the next edge
//   wdata       in   word to transmit, sampled while wreq is high
//   wreq        in   write strobe, one word per high cycle
//   rdy         out  pll_locked and FIFO not full (combinational)
//   tx          out  serial line, registered, idles high
//   busy        out  registered: FSM was active or FIFO held data last cycle
//   overflow    out  sticky: a write arrived while the FIFO was full
//   fifo_level  out  number of stored words, 0 .. 2**FIFO_AW
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUDRATE = 256000,
  parameter int NUM_DATA = 8,
  parameter int FIFO_AW  = 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                pll_locked,
  input  logic [NUM_DATA-1:0] wdata,
  input  logic                wreq,
  output logic                rdy,
  output logic                tx,
  output logic                busy,
  output logic                overflow,
  output logic [FIFO_AW:0]    fifo_level
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int DIV   = CLK_FREQ / BAUDRATE;
  localparam int DEPTH = 1 << FIFO_AW;
  // DIV >= 2 keeps the baud counter at least one bit wide.
  localparam int CNT_W = $clog2(DIV);
  localparam int BIT_W = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NUM_DATA - 1);
  localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  // FIFO
  logic [NUM_DATA-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    level_q, level_d;
  logic                overflow_q;
  logic                busy_q;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic [NUM_DATA-1:0] rd_word;

  // Frame FSM
  state_e              state_q;
  logic [CNT_W-1:0]    baud_cnt_q;
  logic [BIT_W-1:0]    bit_idx_q;
  logic [NUM_DATA-1:0] shift_q;
  logic [NUM_DATA-1:0] shift_nxt;
  logic                tx_q;
  logic                baud_last;
  logic                bit_last;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LEVEL_FULL);

  // A write into a full FIFO is dropped even when a pop happens in the same
  // cycle: fullness is judged on the registered level, with no push-through.
  assign push = wreq && pll_locked && !fifo_full;

  // The FSM takes a word when idle, or on the final cycle of a stop bit so
  // the next start bit follows without an idle gap.
  assign pop = pll_locked && !fifo_empty &&
               ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_last));

  assign rd_word = mem[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    // Pointers wrap naturally modulo the depth.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: the storage array has no reset; the pointers and level decide which
  // entries are valid, and a resetless array can map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

  // NOTE: nrst is the only asynchronous term; pll_locked is a synchronous
  // clear and therefore lives inside the clocked branch.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else if (!pll_locked) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments only, so every
      // register here samples values from before the edge.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (wreq && fifo_full) overflow_q <= 1'b1;
      // busy reflects the previous cycle's FSM state and level.
      busy_q   <= (state_q != S_IDLE) || !fifo_empty;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  assign baud_last = (baud_cnt_q == CNT_LAST);
  assign bit_last  = (bit_idx_q == BIT_LAST);
  assign shift_nxt = shift_q >> 1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else if (!pll_locked) begin
      // Losing lock aborts any frame in flight; the line returns high.
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q    <= rd_word;
            baud_cnt_q <= '0;
            tx_q       <= 1'b0;
            state_q    <= S_START;
          end
        end

        S_START: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= shift_q[0];
            state_q    <= S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            if (bit_last) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              // tx is registered, so it is loaded with the bit that becomes
              // shift_q[0] after this edge.
              bit_idx_q <= bit_idx_q + 1'b1;
              shift_q   <= shift_nxt;
              tx_q      <= shift_nxt[0];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        S_STOP: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            if (pop) begin
              shift_q <= rd_word;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        default: begin
          baud_cnt_q <= '0;
          tx_q       <= 1'b1;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rdy        = pll_locked && !fifo_full;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_level_bound: assert property (@(posedge clk) disable iff (!nrst)
    level_q <= LEVEL_FULL);

  a_idle_stop_high: assert property (@(posedge clk) disable iff (!nrst)
    ((state_q == S_IDLE) || (state_q == S_STOP)) |-> tx_q);

  a_start_low: assert property (@(posedge clk) disable iff (!nrst)
    (state_q == S_START) |-> !tx_q);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Two instances: dut0 at default parameters (DIV = 195) and dut1 with
// CLK_FREQ = 1000, BAUDRATE = 100 (DIV = 10). Stimulus pushes the expected
// byte of every frame into a per-instance queue; a monitor per instance waits
// for a start bit, pops the expected byte and compares the whole frame
// waveform sample by sample plus the mid-bit decoded byte. Cycle-exact
// timing and flag behaviour are checked directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int NB     = 8;
  localparam int DIV0   = 50_000_000 / 256000;   // 195
  localparam int DIV1   = 1000 / 100;            // 10
  localparam int FRAME0 = (NB + 2) * DIV0;        // 1950

  logic       clk;
  logic       nrst;

  logic       pll_locked;
  logic [7:0] wdata;
  logic       wreq;
  logic       rdy;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [4:0] fifo_level;

  logic       pll_locked1;
  logic [7:0] wdata1;
  logic       wreq1;
  logic       rdy1;
  logic       tx1;
  logic       busy1;
  logic       overflow1;
  logic [4:0] fifo_level1;

  uart_tx_serializer dut0 (
    .clk        (clk),
    .nrst       (nrst),
    .pll_locked (pll_locked),
    .wdata      (wdata),
    .wreq       (wreq),
    .rdy        (rdy),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  uart_tx_serializer #(
    .CLK_FREQ (1000),
    .BAUDRATE (100)
  ) dut1 (
    .clk        (clk),
    .nrst       (nrst),
    .pll_locked (pll_locked1),
    .wdata      (wdata1),
    .wreq       (wreq1),
    .rdy        (rdy1),
    .tx         (tx1),
    .busy       (busy1),
    .overflow   (overflow1),
    .fifo_level (fifo_level1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  int         start_log [$];
  bit         mon_abort [2];
  bit         mon_busy  [2];
  int         last_start [2];
  int         last_end   [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic tx_of(input int ch);
    return (ch == 0) ? tx : tx1;
  endfunction

  function automatic logic busy_of(input int ch);
    return (ch == 0) ? busy : busy1;
  endfunction

  function automatic int q_size(input int ch);
    return (ch == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [7:0] q_pop(input int ch);
    if (ch == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  // Advance to cycle c, landing 1 time unit after its opening clock edge.
  task automatic goto_cyc(input int c);
    repeat (c - cyc) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int ch, input int budget, input string name);
    int n;
    n = 0;
    while ((q_size(ch) != 0 || mon_busy[ch] || busy_of(ch) !== 1'b0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= budget) fail_now({name, " timed out"});
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: one frame per start bit, compared against the queued byte
  // ---------------------------------------------------------------------------
  task automatic run_monitor(input int ch);
    int         div;
    int         bad;
    int         t_start;
    bit         aborted;
    logic       s;
    logic       exp_bit;
    logic [7:0] exp_b;
    logic [7:0] got;
    div = (ch == 0) ? DIV0 : DIV1;
    forever begin
      @(negedge clk);
      if (nrst === 1'b1 && !mon_abort[ch] && tx_of(ch) === 1'b0) begin
        t_start      = cyc;
        mon_busy[ch] = 1'b1;
        if (q_size(ch) == 0) begin
          fail_now($sformatf("ch%0d start bit with no word queued", ch));
          for (int i = 1; i < (NB + 2) * div; i++) @(negedge clk);
        end else begin
          exp_b   = q_pop(ch);
          got     = '0;
          bad     = 0;
          aborted = 1'b0;
          for (int i = 0; i < (NB + 2) * div; i++) begin
            if (i > 0) @(negedge clk);
            if (nrst !== 1'b1 || mon_abort[ch]) begin
              aborted = 1'b1;
              break;
            end
            s = tx_of(ch);
            if (i < div)                 exp_bit = 1'b0;
            else if (i < (NB + 1) * div) exp_bit = exp_b[i / div - 1];
            else                         exp_bit = 1'b1;
            if (s !== exp_bit) bad++;
            if (i >= div && i < (NB + 1) * div && (i % div) == div / 2)
              got[i / div - 1] = s;
          end
          if (!aborted) begin
            check($sformatf("ch%0d decoded byte", ch), 32'(got), 32'(exp_b));
            check($sformatf("ch%0d frame samples off-waveform", ch), 32'(bad), 32'd0);
            last_start[ch] = t_start;
            last_end[ch]   = cyc;
            if (ch == 0) start_log.push_back(t_start);
          end
        end
        mon_busy[ch] = 1'b0;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int c0;
    int c1;

    nrst        = 1'b0;
    pll_locked  = 1'b0;
    wreq        = 1'b0;
    wdata       = '0;
    pll_locked1 = 1'b1;
    wreq1       = 1'b0;
    wdata1      = '0;
    mon_abort   = '{1'b0, 1'b0};
    mon_busy    = '{1'b0, 1'b0};
    last_start  = '{0, 0};
    last_end    = '{0, 0};

    fork
      run_monitor(0);
      run_monitor(1);
    join_none

    // ---- Reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("reset tx",         32'(tx),         32'd1);
    check("reset busy",       32'(busy),       32'd0);
    check("reset fifo_level", 32'(fifo_level), 32'd0);
    check("reset overflow",   32'(overflow),   32'd0);
    check("reset rdy unlocked", 32'(rdy),      32'd0);
    check("reset dut1 tx",    32'(tx1),        32'd1);
    pll_locked = 1'b1;
    #1;
    check("reset rdy locked", 32'(rdy),        32'd1);
    nrst = 1'b1;
    goto_cyc(cyc + 2);

    // ---- Single word 0xA5 ----
    c0 = cyc;
    wdata = 8'hA5;
    wreq  = 1'b1;
    exp_q0.push_back(8'hA5);
    goto_cyc(c0 + 1);
    wreq = 1'b0;
    check("single level at +1", 32'(fifo_level), 32'd1);
    check("single tx at +1",    32'(tx),         32'd1);
    goto_cyc(c0 + 2);
    check("single level at +2", 32'(fifo_level), 32'd0);
    check("single tx at +2",    32'(tx),         32'd0);
    check("single busy at +2",  32'(busy),       32'd1);
    goto_cyc(c0 + 1952);
    check("single tx at +1952",   32'(tx),   32'd1);
    check("single busy at +1952", 32'(busy), 32'd1);
    goto_cyc(c0 + 1953);
    check("single busy at +1953", 32'(busy), 32'd0);
    check("single start cycle", 32'(last_start[0] - c0), 32'd2);
    check("single end cycle",   32'(last_end[0] - c0),   32'd1951);

    // ---- Back-to-back 0x00, 0xFF, 0x3C ----
    start_log.delete();
    c0 = cyc;
    wreq = 1'b1;
    wdata = 8'h00; exp_q0.push_back(8'h00);
    goto_cyc(c0 + 1);
    wdata = 8'hFF; exp_q0.push_back(8'hFF);
    goto_cyc(c0 + 2);
    wdata = 8'h3C; exp_q0.push_back(8'h3C);
    goto_cyc(c0 + 3);
    wreq = 1'b0;
    check("b2b level at +3", 32'(fifo_level), 32'd2);
    wait_idle(0, 4 * FRAME0, "b2b drain");
    check("b2b frame count", 32'(start_log.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      check($sformatf("b2b frame %0d start", k),
            32'((k < start_log.size()) ? start_log[k] - c0 : -1),
            32'(2 + k * FRAME0));
    check("b2b last stop cycle", 32'(last_end[0] - c0), 32'(1 + 3 * FRAME0));

    // ---- Overflow: 18 consecutive writes, words 1..18 ----
    c0 = cyc;
    for (int k = 0; k < 18; k++) begin
      wdata = 8'(k + 1);
      wreq  = 1'b1;
      if (k < 17) exp_q0.push_back(8'(k + 1));
      if (k == 16) begin
        check("ovf level at +16", 32'(fifo_level), 32'd15);
        check("ovf rdy at +16",   32'(rdy),        32'd1);
      end
      if (k == 17) begin
        check("ovf level at +17",    32'(fifo_level), 32'd16);
        check("ovf rdy at +17",      32'(rdy),        32'd0);
        check("ovf overflow at +17", 32'(overflow),   32'd0);
      end
      goto_cyc(c0 + k + 1);
    end
    wreq = 1'b0;
    check("ovf overflow at +18", 32'(overflow),   32'd1);
    check("ovf level at +18",    32'(fifo_level), 32'd16);
    // Write while full on the cycle the FSM pops: must be dropped.
    goto_cyc(c0 + 1951);
    check("ovf level before pop", 32'(fifo_level), 32'd16);
    wdata = 8'hEE;
    wreq  = 1'b1;
    goto_cyc(c0 + 1952);
    wreq = 1'b0;
    check("ovf no push-through", 32'(fifo_level), 32'd15);
    wait_idle(0, 18 * FRAME0, "ovf drain");
    check("ovf overflow sticky", 32'(overflow), 32'd1);

    // ---- Lock loss during DATA bit 3 with 5 words queued ----
    c0 = cyc;
    for (int k = 0; k < 5; k++) begin
      wdata = 8'(8'h11 * (k + 1));
      wreq  = 1'b1;
      exp_q0.push_back(8'(8'h11 * (k + 1)));
      goto_cyc(c0 + k + 1);
    end
    wreq = 1'b0;
    goto_cyc(c0 + 800);
    check("lock busy before",  32'(busy),       32'd1);
    check("lock level before", 32'(fifo_level), 32'd4);
    pll_locked   = 1'b0;
    mon_abort[0] = 1'b1;
    #1;
    check("lock rdy immediate", 32'(rdy), 32'd0);
    goto_cyc(c0 + 801);
    check("lock tx",       32'(tx),         32'd1);
    check("lock level",    32'(fifo_level), 32'd0);
    check("lock busy",     32'(busy),       32'd0);
    check("lock overflow", 32'(overflow),   32'd0);
    check("lock rdy",      32'(rdy),        32'd0);
    exp_q0.delete();
    goto_cyc(c0 + 804);
    check("lock tx held", 32'(tx), 32'd1);
    pll_locked = 1'b1;
    #1;
    check("relock rdy", 32'(rdy), 32'd1);
    goto_cyc(c0 + 806);
    mon_abort[0] = 1'b0;
    c1 = cyc;
    wdata = 8'h5A;
    wreq  = 1'b1;
    exp_q0.push_back(8'h5A);
    goto_cyc(c1 + 1);
    wreq = 1'b0;
    wait_idle(0, 2 * FRAME0, "relock frame");
    check("relock start cycle", 32'(last_start[0] - c1), 32'd2);

    // ---- Asynchronous reset during STOP ----
    c0 = cyc;
    wreq = 1'b1;
    wdata = 8'hC3; exp_q0.push_back(8'hC3);
    goto_cyc(c0 + 1);
    wdata = 8'h99; exp_q0.push_back(8'h99);
    goto_cyc(c0 + 2);
    wreq = 1'b0;
    goto_cyc(c0 + 1800);
    check("areset busy before",  32'(busy),       32'd1);
    check("areset level before", 32'(fifo_level), 32'd1);
    #3;
    mon_abort[0] = 1'b1;
    nrst = 1'b0;
    #1;
    check("areset tx",       32'(tx),         32'd1);
    check("areset busy",     32'(busy),       32'd0);
    check("areset level",    32'(fifo_level), 32'd0);
    check("areset overflow", 32'(overflow),   32'd0);
    check("areset rdy",      32'(rdy),        32'd1);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    exp_q0.delete();
    goto_cyc(cyc + 2);
    mon_abort[0] = 1'b0;
    check("areset tx after release",    32'(tx),   32'd1);
    check("areset busy after release",  32'(busy), 32'd0);
    c1 = cyc;
    wdata = 8'h96;
    wreq  = 1'b1;
    exp_q0.push_back(8'h96);
    goto_cyc(c1 + 1);
    wreq = 1'b0;
    wait_idle(0, 2 * FRAME0, "post-reset frame");
    check("post-reset start cycle", 32'(last_start[0] - c1), 32'd2);

    // ---- Non-default divisor: 0x81 at DIV = 10 ----
    c0 = cyc;
    wdata1 = 8'h81;
    wreq1  = 1'b1;
    exp_q1.push_back(8'h81);
    goto_cyc(c0 + 1);
    wreq1 = 1'b0;
    check("div10 level at +1", 32'(fifo_level1), 32'd1);
    wait_idle(1, 400, "div10 frame");
    check("div10 start cycle",  32'(last_start[1] - c0), 32'd2);
    check("div10 frame length", 32'(last_end[1] - last_start[1] + 1), 32'(10 * DIV1));
    check("div10 tx idle",      32'(tx1),       32'd1);
    check("div10 rdy",          32'(rdy1),      32'd1);
    check("div10 overflow",     32'(overflow1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit stage that sits directly downstream of the ADC control FSM. It accepts one-cycle `wreq` pulses carrying a data word, buffers them in a small FIFO, and serialises each word onto `tx` as an 8N1-style frame at the configured baud rate. It returns `rdy` to the FSM as back-pressure.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUDRATE`, 256000: line rate; `DIV = CLK_FREQ / BAUDRATE`, integer-truncated (195 at defaults); `DIV` ≥ 2.
- `NUM_DATA`, 8: data bits per frame.
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW (16).
- `clk`  in  1  system clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `pll_locked`  in  1  low = synchronous clear of FIFO, FSM and `overflow`.
- `wdata`  in  NUM_DATA  word to transmit; sampled when `wreq`=1.
- `wreq`  in  1  write strobe; one word per high cycle.
- `rdy`  out  1  `pll_locked` && FIFO not full (combinational).
- `tx`  out  1  serial line, registered; idle high.
- `busy`  out  1  FSM not IDLE, or FIFO not empty.
- `overflow`  out  1  sticky; set when `wreq` arrives while full.
- `fifo_level`  out  FIFO_AW+1  number of stored words, 0..2^FIFO_AW.

## Operation
- **Reset** (`nrst`=0, async) and **`pll_locked`=0** (sync) put the block in this state:
  - `tx`=1, FSM=IDLE, FIFO empty, `fifo_level`=0, `overflow`=0.
  - `busy`=0; `rdy` = `pll_locked`.
- **Push:**
  - `wreq`=1 and not full: store `wdata`; `fifo_level` increments at the next edge.
  - `wreq`=1 and full: word dropped, `overflow`←1. This holds even if a pop occurs in the same cycle; no push-through.
- **Pop:** simultaneous push+pop with the FIFO not full leaves `fifo_level` unchanged. Pointers wrap modulo 2^FIFO_AW.
- **FSM states:** IDLE, START, DATA, STOP. One counter `baud_cnt` (0..DIV-1) and one bit counter `bit_idx` (0..NUM_DATA-1).
  - **IDLE:** `tx`=1. If FIFO not empty: pop into the shift register, clear `baud_cnt`, → START.
  - **START:** `tx`=0 for DIV cycles, then → DATA with `bit_idx`=0.
  - **DATA:** `tx` = shift[0], LSB first, each bit held DIV cycles. After bit NUM_DATA-1 → STOP.
  - **STOP:** `tx`=1 for DIV cycles. On the last STOP cycle:
    - FIFO not empty: pop and go directly to START (no idle gap).
    - Otherwise: → IDLE.
- **Frame length:** exactly (NUM_DATA+2)·DIV cycles. Back-to-back frames are contiguous.
- **Mid-frame clear:** `pll_locked` falling mid-frame aborts the frame. `tx`=1 from the next edge; the remaining FIFO contents are discarded.
- `overflow` clears only on reset or `pll_locked`=0.

## Timing
- `wreq` at cycle 0 into an empty FIFO, FSM IDLE:
  - `fifo_level`=1 at cycle 1.
  - IDLE pops at cycle 1; `tx` falls at cycle 2.
  - Push-to-start-bit latency is 2 cycles.
- `rdy` reflects the current `fifo_level`. A word pushed at cycle n makes `rdy` fall at cycle n+1 if it fills the FIFO.
- `busy` is registered from state/level. It falls the cycle after the last STOP cycle when the FIFO is empty.
- All outputs except `rdy` are registered.

## Test plan
- **Single word:** `wdata`=0xA5 pulsed at cycle 0 (defaults) ->
  - `tx` low cycles 2..196.
  - Then bits 1,0,1,0,0,1,0,1, each 195 cycles.
  - Stop high 195 cycles.
  - `busy` low at cycle 1953; `fifo_level` back to 0 at cycle 2.
- **Back-to-back:** 0x00, 0xFF, 0x3C on consecutive cycles -> three contiguous frames, no idle gap. `tx` high again at cycle 2+5850; the decoded byte sequence matches.
- **Overflow:** `wreq` held high 18 consecutive cycles, words 1..18 ->
  - Words 1..17 accepted; `fifo_level`=16 at cycle 17.
  - `rdy`=0 from cycle 17; word 18 dropped; `overflow`=1 at cycle 18.
  - Words 1..17 transmitted in order.
- **Lock loss mid-frame:** drop `pll_locked` during DATA bit 3 with 5 words queued ->
  - Next edge: `tx`=1, `fifo_level`=0, `busy`=0, `overflow`=0, `rdy`=0.
  - After relock, a new 0x5A is sent cleanly.
- **Async reset mid-STOP:** assert `nrst` between edges -> `tx`=1 and all outputs at reset values immediately, without waiting for a clock edge.
- **Non-default divisor:** `CLK_FREQ`=1000, `BAUDRATE`=100 (DIV=10) -> 0x81 frame is exactly 100 cycles; bit 0 and bit 7 high, bits 1..6 low.
